nanorv32_sim_monitor: RTL and testbench

Synthesizable, parametrised run monitor for nanorv32 simulation and FPGA self-test. Watches the retired PC and register a0 and decides the test verdict: pass, fail, unknown, illegal instruction, timeout or X-PC. It captures debug-printf characters into a line FIFO, and a host or UART drains them over a valid/ready interface. Sits beside the core in the test harness, fed from core debug taps.

---
 rtl/nanorv32_sim_monitor_if.sv | 26 ++
 rtl/nanorv32_sim_monitor.sv | 111 +++++++++++
 tb/tb_nanorv32_sim_monitor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_sim_monitor_if.sv
// Debug-tap and printf-drain signals between the nanorv32 harness and its run monitor.
interface nanorv32_sim_monitor_if #(
    parameter int CYC_W = 32
);
    logic [31:0]      pc_i;
    logic             pc_valid_i;
    logic [31:0]      a0_i;
    logic             illegal_i;
    logic             done_o;
    logic [2:0]       status_o;
    logic             char_valid_o;
    logic [7:0]       char_o;
    logic             char_ready_i;
    logic             line_flush_o;
    logic             overflow_o;
    logic [CYC_W-1:0] cycle_count_o;

    modport master (
        output pc_i, pc_valid_i, a0_i, illegal_i, char_ready_i,
        input  done_o, status_o, char_valid_o, char_o, line_flush_o, overflow_o, cycle_count_o
    );
    modport slave (
        input  pc_i, pc_valid_i, a0_i, illegal_i, char_ready_i,
        output done_o, status_o, char_valid_o, char_o, line_flush_o, overflow_o, cycle_count_o
    );
endinterface

// File: rtl/nanorv32_sim_monitor.sv
// nanorv32 run monitor: verdict FSM, saturating cycle counter and printf FWFT FIFO.
// Optional macro NANORV32_MON_XCHECK_EN adds the simulation-only X-PC verdict (code 6).
module nanorv32_sim_monitor #(
    parameter logic [31:0] PASS_PC        = 32'h0000_0100,
    parameter logic [31:0] PRINTF_PC      = 32'h0000_0088,
    parameter logic [31:0] PASS_MAGIC     = 32'hCAFF_E000,
    parameter logic [31:0] FAIL_MAGIC     = 32'hDEAD_0000,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter int          BUF_DEPTH      = 16,
    parameter int          CYC_W          = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    nanorv32_sim_monitor_if.slave mon
);
    localparam int               AW      = $clog2(BUF_DEPTH);
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_UNKNOWN = 3'd3;
    localparam logic [2:0] ST_ILLEGAL = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;
    localparam logic [2:0] ST_PC_X    = 3'd6;

    typedef enum logic {RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       status, status_nxt;
    logic [CYC_W-1:0] cycle_count;
    logic             evt, pass_hit, to_hit, pc_x;

    assign pass_hit = mon.pc_valid_i && (mon.pc_i == PASS_PC);
    assign to_hit   = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);

`ifdef NANORV32_MON_XCHECK_EN
    assign pc_x = mon.pc_valid_i && ((^mon.pc_i) === 1'bx);
`else
    assign pc_x = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        evt        = 1'b0;
        if (state == RUN) begin
            evt = 1'b1;
            if (mon.illegal_i)                status_nxt = ST_ILLEGAL;
            else if (pc_x)                    status_nxt = ST_PC_X;
            else if (pass_hit) begin
                if (mon.a0_i == PASS_MAGIC)      status_nxt = ST_PASS;
                else if (mon.a0_i == FAIL_MAGIC) status_nxt = ST_FAIL;
                else                             status_nxt = ST_UNKNOWN;
            end
            else if (to_hit)                  status_nxt = ST_TIMEOUT;
            else                              evt = 1'b0;
            if (evt) state_nxt = DONE;
        end
    end

    // The verdict cycle does not count, so a timeout leaves the counter at TIMEOUT_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            status      <= '0;
            cycle_count <= '0;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
            if (state == RUN && !evt && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    logic [7:0]  mem [BUF_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_req, push, line_flush, overflow;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && mon.char_ready_i;
    assign push_req = (state == RUN) && mon.pc_valid_i && (mon.pc_i == PRINTF_PC);
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            line_flush <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            line_flush <= pop && (mem[rd_ptr[AW-1:0]] == 8'h0A);
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: char_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= mon.a0_i[7:0];
    end

    assign mon.done_o        = (state == DONE);
    assign mon.status_o      = status;
    assign mon.char_valid_o  = !empty;
    assign mon.char_o        = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign mon.line_flush_o  = line_flush;
    assign mon.overflow_o    = overflow;
    assign mon.cycle_count_o = cycle_count;
endmodule

// File: tb/tb_nanorv32_sim_monitor.sv
// Randomised and directed bench for nanorv32_sim_monitor against a queue-based verdict/log model.
module tb_nanorv32_sim_monitor;
    localparam logic [31:0] PASS_PC    = 32'h0000_0100;
    localparam logic [31:0] PRINTF_PC  = 32'h0000_0088;
    localparam logic [31:0] PASS_MAGIC = 32'hCAFF_E000;
    localparam logic [31:0] FAIL_MAGIC = 32'hDEAD_0000;
    localparam int          TIMEOUT    = 50;
    localparam int          DEPTH      = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nanorv32_sim_monitor_if #(.CYC_W(32)) bus ();

    nanorv32_sim_monitor #(
        .PASS_PC(PASS_PC), .PRINTF_PC(PRINTF_PC), .PASS_MAGIC(PASS_MAGIC),
        .FAIL_MAGIC(FAIL_MAGIC), .TIMEOUT_CYCLES(TIMEOUT), .BUF_DEPTH(DEPTH), .CYC_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon(bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int flush_cnt = 0;

    // Reference model state
    bit          m_done;
    logic [2:0]  m_status;
    logic [31:0] m_count;
    bit          m_ovf, m_flush;
    logic [7:0]  q[$];
    logic [7:0]  drained[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model step and per-cycle compare, 1 time unit after each rising edge.
    always begin : model_cmp
        logic        s_rst, s_pv, s_ill, s_rdy, pop, psh, full, pcx;
        logic [31:0] s_pc, s_a0;
        logic [2:0]  code;
        @(posedge clk);
        s_rst = rst_n; s_pv = bus.pc_valid_i; s_pc = bus.pc_i; s_a0 = bus.a0_i;
        s_ill = bus.illegal_i; s_rdy = bus.char_ready_i;
        #1;
        if (!s_rst) begin
            m_done = 0; m_status = 0; m_count = 0; m_ovf = 0; m_flush = 0; q.delete();
        end else begin
            pop  = (q.size() != 0) && s_rdy;
            psh  = !m_done && s_pv && (s_pc == PRINTF_PC);
            full = (q.size() == DEPTH);
`ifdef NANORV32_MON_XCHECK_EN
            pcx = s_pv && ((^s_pc) === 1'bx);
`else
            pcx = 1'b0;
`endif
            if (!m_done) begin
                code = 0;
                if (s_ill) code = 4;
                else if (pcx) code = 6;
                else if (s_pv && s_pc == PASS_PC)
                    code = (s_a0 == PASS_MAGIC) ? 3'd1 : (s_a0 == FAIL_MAGIC) ? 3'd2 : 3'd3;
                else if (TIMEOUT != 0 && m_count == TIMEOUT - 1) code = 5;
                if (code != 0) begin m_done = 1; m_status = code; end
                else if (m_count != 32'hFFFF_FFFF) m_count++;
            end
            m_flush = pop && (q[0] == 8'h0A);
            if (pop) begin drained.push_back(q[0]); void'(q.pop_front()); end
            if (psh) begin
                if (full && !pop) m_ovf = 1;
                else q.push_back(s_a0[7:0]);
            end
        end
        if (bus.line_flush_o === 1'b1) flush_cnt++;
        if (chk_en) begin
            check("done", bus.done_o, m_done);
            check("status", bus.status_o, m_status);
            check("char_valid", bus.char_valid_o, q.size() != 0);
            check("char", bus.char_o, (q.size() != 0) ? q[0] : 8'h00);
            check("line_flush", bus.line_flush_o, m_flush);
            check("overflow", bus.overflow_o, m_ovf);
            check("cycle_count", bus.cycle_count_o, m_count);
        end
    end

    task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] a0,
                        input logic ill, input logic rdy);
        bus.pc_valid_i = pv; bus.pc_i = pc; bus.a0_i = a0;
        bus.illegal_i = ill; bus.char_ready_i = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2, 1'b0);
        chk_en = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] frozen, pc, a0;
        rst_n = 1'b0;
        bus.pc_valid_i = 0; bus.pc_i = 0; bus.a0_i = 0; bus.illegal_i = 0; bus.char_ready_i = 0;
        @(negedge clk);

        // 1: printf "Hi\n" drains in order with one line flush
        do_reset();
        check("reset_done", bus.done_o, 1'b0);
        check("reset_count", bus.cycle_count_o, 32'd0);
        drained.delete(); flush_cnt = 0;
        step(1, PRINTF_PC, 32'h48, 0, 1);
        step(1, PRINTF_PC, 32'h69, 0, 1);
        step(1, PRINTF_PC, 32'h0A, 0, 1);
        idle(4, 1'b1);
        check("t1_n", drained.size(), 3);
        if (drained.size() == 3) begin
            check("t1_c0", drained[0], 8'h48);
            check("t1_c1", drained[1], 8'h69);
            check("t1_c2", drained[2], 8'h0A);
        end
        check("t1_flush", flush_cnt, 1);
        check("t1_done", bus.done_o, 1'b0);

        // 2: pass verdict, later events ignored, counter frozen
        step(1, PASS_PC, PASS_MAGIC, 0, 1);
        check("t2_done", bus.done_o, 1'b1);
        check("t2_status", bus.status_o, 3'd1);
        frozen = bus.cycle_count_o;
        step(1, PASS_PC, FAIL_MAGIC, 0, 1);
        idle(3, 1'b1);
        check("t2_sticky", bus.status_o, 3'd1);
        check("t2_frozen", bus.cycle_count_o, frozen);

        // 3: fail and unknown
        do_reset();
        step(1, PASS_PC, FAIL_MAGIC, 0, 1);
        check("t3_fail", bus.status_o, 3'd2);
        do_reset();
        step(1, PASS_PC, 32'h1234_5678, 0, 1);
        check("t3_unknown", bus.status_o, 3'd3);

        // 4: illegal beats pass; timeout with no events
        do_reset();
        step(1, PASS_PC, PASS_MAGIC, 1, 1);
        check("t4_illegal", bus.status_o, 3'd4);
        do_reset();
        idle(60, 1'b1);
        check("t4_timeout", bus.status_o, 3'd5);
        check("t4_count", bus.cycle_count_o, 32'd49);

        // 5: overflow with ready low, then full-with-pop accepts the push
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) step(1, PRINTF_PC, 32'h30 + i, 0, 0);
        check("t5_ovf", bus.overflow_o, 1'b1);
        check("t5_head", bus.char_o, 8'h30);
        drained.delete();
        step(1, PRINTF_PC, 32'h5A, 0, 1);
        idle(20, 1'b1);
        check("t5_n", drained.size(), 17);
        if (drained.size() == 17) begin
            check("t5_first", drained[0], 8'h30);
            check("t5_last16", drained[15], 8'h3F);
            check("t5_late", drained[16], 8'h5A);
        end

        // 6: X on the retired PC
        do_reset();
        step(1, 32'hxxxx_xxxx, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
`ifdef NANORV32_MON_XCHECK_EN
        check("t6_pcx", bus.status_o, 3'd6);
`else
        check("t6_nopcx", bus.status_o, 3'd0);
        check("t6_nodone", bus.done_o, 1'b0);
`endif

        // Random runs checked cycle by cycle against the model
        for (int run = 0; run < 40; run++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                int r, s;
                r = $urandom_range(99);
                pc = (r < 6) ? PASS_PC : (r < 55) ? PRINTF_PC : $urandom;
                s = $urandom_range(3);
                a0 = (s == 0) ? PASS_MAGIC : (s == 1) ? FAIL_MAGIC :
                     ($urandom_range(5) == 0) ? 32'h0A : $urandom;
                step(1'($urandom_range(1)), pc, a0, ($urandom_range(99) < 2),
                     ($urandom_range(3) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
